load_store_unit: RTL and testbench

- Data-memory access block for the single-cycle RV64 datapath. It sits between the execute stage and the 64-bit data memory, and it is the write source for the register file on loads.
- Takes one load/store request at a time, checks alignment, and drives a doubleword-wide memory bus with byte strobes.
- Extracts and extends load data, then presents a one-cycle register-file write (RegWrite/writereg/writedata).
- Stalls the core through a ready signal until the access completes.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/lsu_align.sv | 73 +++++++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 codes, opcodes and FSM encoding for the load/store unit
package load_store_unit_pkg;

    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SD  = 3'b011;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SH  = 3'b001;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WB     = 2'b10,
        S_ERR    = 2'b11
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational alignment check, store lane placement and load extension
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic        err,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_lane,
    output logic [63:0] load_data
);

    logic [5:0]  sh;
    logic [63:0] s;

    assign sh = {off, 3'b000};
    assign s  = rdata >> sh;

    always_comb begin
        err        = 1'b0;
        wstrb      = 8'h00;
        wdata_lane = 64'h0;
        load_data  = 64'h0;
        if (store == OP_STORE) begin
            case (funct3)
                F3_SD: begin
                    err        = (off != 3'b000);
                    wstrb      = 8'hFF;
                    wdata_lane = wdata;
                end
                F3_SW: begin
                    err        = (off[1:0] != 2'b00);
                    wstrb      = 8'h0F << off;
                    wdata_lane = {32'h0, wdata[31:0]} << sh;
                end
                F3_SH: begin
                    err        = off[0];
                    wstrb      = 8'h03 << off;
                    wdata_lane = {48'h0, wdata[15:0]} << sh;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LD: begin
                    err       = (off != 3'b000);
                    load_data = s;
                end
                F3_LW: begin
                    err       = (off[1:0] != 2'b00);
                    load_data = {{32{s[31]}}, s[31:0]};
                end
                F3_LWU: begin
                    err       = (off[1:0] != 2'b00);
                    load_data = {32'h0, s[31:0]};
                end
                F3_LH: begin
                    err       = off[0];
                    load_data = {{48{s[15]}}, s[15:0]};
                end
                F3_LHU: begin
                    err       = off[0];
                    load_data = {48'h0, s[15:0]};
                end
                default: err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit: FSM, timeout counter, bus and writeback registers
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [63:0]       wb_data,
    output logic              store_done,
    output logic              lsu_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        cap_store;
    logic [2:0]  cap_funct3;
    logic [2:0]  cap_off;
    logic [4:0]  cap_rd;
    logic [7:0]  cnt;

    logic        idle;
    logic        a_store;
    logic [2:0]  a_funct3;
    logic [2:0]  a_off;
    logic        a_err;
    logic [7:0]  a_wstrb;
    logic [63:0] a_wdata;
    logic [63:0] a_load;

    assign idle      = (state == S_IDLE);
    assign req_ready = idle;

    // One aligner serves both phases: request fields while idle, captured fields afterwards.
    assign a_store  = idle ? req_store      : cap_store;
    assign a_funct3 = idle ? req_funct3     : cap_funct3;
    assign a_off    = idle ? req_addr[2:0]  : cap_off;

    lsu_align u_align (
        .store      (a_store),
        .funct3     (a_funct3),
        .off        (a_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .err        (a_err),
        .wstrb      (a_wstrb),
        .wdata_lane (a_wdata),
        .load_data  (a_load)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            cap_store  <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_off    <= 3'b000;
            cap_rd     <= 5'd0;
            cnt        <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 64'h0;
            mem_wstrb  <= 8'h00;
            wb_valid   <= 1'b0;
            wb_reg     <= 5'd0;
            wb_data    <= 64'h0;
            store_done <= 1'b0;
            lsu_err    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            store_done <= 1'b0;
            lsu_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (a_err) begin
                            state   <= S_ERR;
                            lsu_err <= 1'b1;
                        end else begin
                            state      <= S_ACCESS;
                            cap_store  <= req_store;
                            cap_funct3 <= req_funct3;
                            cap_off    <= req_addr[2:0];
                            cap_rd     <= req_rd;
                            cnt        <= 8'd0;
                            mem_req    <= 1'b1;
                            mem_we     <= req_store;
                            mem_addr   <= {req_addr[ADDR_W-1:3], 3'b000};
                            mem_wdata  <= a_wdata;
                            mem_wstrb  <= a_wstrb;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack on the final timeout cycle still completes the access.
                    if (mem_ack || cnt == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 64'h0;
                        mem_wstrb <= 8'h00;
                    end
                    if (mem_ack) begin
                        if (cap_store) begin
                            state      <= S_IDLE;
                            store_done <= 1'b1;
                        end else begin
                            state    <= S_WB;
                            wb_valid <= (cap_rd != 5'd0);
                            wb_reg   <= cap_rd;
                            wb_data  <= a_load;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_ERR;
                        lsu_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_WB:    state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        store_done;
    logic        lsu_err;

    int checks = 0;
    int errors = 0;
    int low    = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(64), .TIMEOUT(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .store_done (store_done),
        .lsu_err    (lsu_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic ack_after(input int n, input logic [63:0] rd);
        for (int i = 0; i < n; i++) begin
            if (!req_ready) low++;
            step();
        end
        if (!req_ready) low++;
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 64'h0; req_wdata = 64'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", req_ready, 1);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_lsu_err", lsu_err, 0);
        nrst = 1'b1;
        step();

        // LD 0x100, ack after 2 waiting cycles
        issue(1'b0, 3'b011, 64'h100, 64'h0, 5'd5);
        chk("ld_mem_req", mem_req, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 64'h100);
        chk("ld_wstrb", mem_wstrb, 8'h00);
        low = 0;
        ack_after(2, 64'h1122334455667788);
        if (!req_ready) low++;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_reg", wb_reg, 5);
        chk("ld_wb_data", wb_data, 64'h1122334455667788);
        chk("ld_mem_req_drop", mem_req, 0);
        step();
        chk("ld_wb_pulse_end", wb_valid, 0);
        chk("ld_ready_back", req_ready, 1);
        chk("ld_ready_low_cycles", low, 4);

        // LW / LWU at 0x104
        issue(1'b0, 3'b010, 64'h104, 64'h0, 5'd6);
        chk("lw_mem_addr", mem_addr, 64'h100);
        ack_after(0, 64'h8000000100000000);
        chk("lw_wb_data", wb_data, 64'hFFFFFFFF80000001);
        step();
        issue(1'b0, 3'b110, 64'h104, 64'h0, 5'd7);
        ack_after(0, 64'h8000000100000000);
        chk("lwu_wb_data", wb_data, 64'h0000000080000001);
        chk("lwu_wb_reg", wb_reg, 7);
        step();

        // LHU at 0x106
        issue(1'b0, 3'b101, 64'h106, 64'h0, 5'd8);
        ack_after(1, 64'h8001000000000000);
        chk("lhu_wb_data", wb_data, 64'h0000000000008001);
        step();

        // SH at 0x10A
        issue(1'b1, 3'b001, 64'h10A, 64'hABCD, 5'd0);
        chk("sh_mem_we", mem_we, 1);
        chk("sh_mem_addr", mem_addr, 64'h108);
        chk("sh_wstrb", mem_wstrb, 8'h0C);
        chk("sh_wdata", mem_wdata, 64'h00000000ABCD0000);
        ack_after(0, 64'h0);
        chk("sh_store_done", store_done, 1);
        chk("sh_wb_valid", wb_valid, 0);
        chk("sh_ready", req_ready, 1);
        chk("sh_mem_req_drop", mem_req, 0);
        step();
        chk("sh_store_done_end", store_done, 0);

        // SD and SW lanes
        issue(1'b1, 3'b011, 64'h200, 64'h0123456789ABCDEF, 5'd0);
        chk("sd_wstrb", mem_wstrb, 8'hFF);
        chk("sd_wdata", mem_wdata, 64'h0123456789ABCDEF);
        ack_after(0, 64'h0);
        step();
        issue(1'b1, 3'b010, 64'h204, 64'hFFFFFFFFDEADBEEF, 5'd0);
        chk("sw_wstrb", mem_wstrb, 8'hF0);
        chk("sw_wdata", mem_wdata, 64'hDEADBEEF00000000);
        ack_after(0, 64'h0);
        step();

        // misaligned LW
        issue(1'b0, 3'b010, 64'h102, 64'h0, 5'd9);
        chk("mis_lsu_err", lsu_err, 1);
        chk("mis_mem_req", mem_req, 0);
        chk("mis_ready_low", req_ready, 0);
        step();
        chk("mis_err_end", lsu_err, 0);
        chk("mis_ready_back", req_ready, 1);
        chk("mis_no_wb", wb_valid, 0);

        // illegal store funct3
        issue(1'b1, 3'b110, 64'h100, 64'h0, 5'd0);
        chk("ill_lsu_err", lsu_err, 1);
        chk("ill_mem_req", mem_req, 0);
        step();

        // LH with rd = 0
        issue(1'b0, 3'b001, 64'h106, 64'h0, 5'd0);
        chk("lh_x0_mem_req", mem_req, 1);
        ack_after(1, 64'h8001000000000000);
        chk("lh_x0_wb_valid", wb_valid, 0);
        chk("lh_x0_in_wb", req_ready, 0);
        step();
        chk("lh_x0_ready", req_ready, 1);

        // ack on the last timeout cycle still completes
        issue(1'b0, 3'b011, 64'h300, 64'h0, 5'd3);
        ack_after(3, 64'h55AA);
        chk("late_ack_wb_valid", wb_valid, 1);
        chk("late_ack_err", lsu_err, 0);
        chk("late_ack_data", wb_data, 64'h55AA);
        step();

        // timeout, then stray ack
        issue(1'b0, 3'b011, 64'h300, 64'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req_held", mem_req, 1);
            chk("to_no_err_yet", lsu_err, 0);
            step();
        end
        chk("to_lsu_err", lsu_err, 1);
        chk("to_mem_req_drop", mem_req, 0);
        step();
        chk("to_err_end", lsu_err, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("stray_wb_valid", wb_valid, 0);
        chk("stray_store_done", store_done, 0);
        chk("stray_ready", req_ready, 1);
        step();
        chk("stray_ready_after", req_ready, 1);
        chk("stray_wb_valid_after", wb_valid, 0);

        // asynchronous reset during ACCESS
        issue(1'b1, 3'b011, 64'h400, 64'hFFFF, 5'd0);
        chk("rst_mem_req_before", mem_req, 1);
        #2 nrst = 1'b0;
        #1;
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_ready", req_ready, 1);
        step();
        nrst = 1'b1;
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_mem_wstrb", mem_wstrb, 8'h00);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wb_reg", wb_reg, 0);
        chk("rst_wb_data", wb_data, 64'h0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rst_late_ack_done", store_done, 0);
        chk("rst_late_ack_ready", req_ready, 1);
        chk("rst_late_ack_mem_req", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
